var_delay_line: RTL and testbench
=================================

// Module: var_delay_line
//
// PURPOSE
//   Parametrised, run-time-selectable pipeline delay for a WIDTH-bit sample
//   stream with per-sample valid tracking, stall (enable) and synchronous flush.
//   Generalises the fixed two-cycle register delay. It sits in the datapath to
//   align streams with differing latencies.
//
// PARAMETERS
//   WIDTH      8   data width in bits (>= 1)
//   MAX_DEPTH  8   number of delay stages implemented (>= 1)
//   DELAY_W    4   width of the delay port; 2**DELAY_W must exceed MAX_DEPTH
//                  (elaboration-time check, $error on violation)
//
// PORTS
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous, active-low reset
//   en       in   1          shift enable; 0 = stall (all stages hold)
//   clear    in   1          synchronous flush, priority over en
//   delay    in   DELAY_W    requested latency in clock edges
//   d        in   WIDTH      input sample
//   d_valid  in   1          d carries a real sample
//   q        out  WIDTH      delayed sample
//   q_valid  out  1          q carries a real sample
//
// BEHAVIOUR
// - Storage: stages S[1..MAX_DEPTH], each holding {data[WIDTH-1:0], valid}.
// - Reset (rst_n = 0, asynchronous): every stage data = 0 and valid = 0.
//   q = 0 and q_valid = 0 immediately, without waiting for a clock edge.
//   Deassertion is synchronised outside this block.
// - Rising edge, clear = 1: every stage data = 0 and valid = 0, whatever en is.
//   d is not captured on that edge.
// - Rising edge, clear = 0, en = 1: S[1] <= {d, d_valid}; S[k] <= S[k-1] for
//   k = 2..MAX_DEPTH. The oldest stage is discarded.
// - Rising edge, clear = 0, en = 0: all stages hold. d and d_valid are ignored.
// - Effective delay: eff = 1 if delay == 0; MAX_DEPTH if delay > MAX_DEPTH;
//   otherwise delay.
// - Output: {q, q_valid} = S[eff]. This is a combinational mux from registers,
//   with no extra register stage.
// - Latency: with en = 1 held, q after edge n equals the d sampled at edge
//   n - eff + 1. Example: delay = 2 means q shows the d that was present two
//   edges earlier.
// - Changing delay: takes effect combinationally in the same cycle, with no
//   flush. Shortening the delay skips intermediate samples. Lengthening it
//   re-presents older samples; their valid bits are truthful, so stale or
//   unfilled stages show q_valid = 0.
// - Samples with d_valid = 0 still shift; their data is carried but flagged
//   invalid.
// - Simultaneous clear and en: clear wins.
// - rst_n asserted mid-stream: all state is lost; there is no partial hold.
// - No combinational path from d to q.
//
// TESTING
//  1. Reset: rst_n = 0 mid-stream, off any clock edge -> q = 0, q_valid = 0
//     immediately; both stay 0 until 2 edges after release with
//     en = d_valid = 1, delay = 2.
//  2. Fixed delay: WIDTH = 8, MAX_DEPTH = 8, delay = 2, en = 1, d_valid = 1,
//     256 samples from a 16-bit LFSR (taps 0, 2, 3, 5, d = lfsr[7:0]) -> from
//     the 2nd edge on, q equals d from 2 edges earlier; 0 mismatches.
//  3. Clamping: delay = 8 -> latency 8 edges; delay = 0 -> latency 1;
//     delay = 15 -> latency 8, with q_valid low for the first 7 edges.
//  4. Stall: delay = 3, stream d = 1, 2, 3, ...; hold en = 0 for 3 cycles
//     while d keeps changing -> q and q_valid frozen. On resume the output
//     sequence continues with no sample lost or duplicated.
//  5. Flush: clear = 1 for 1 edge with en = 1 -> q = 0, q_valid = 0 after
//     that edge. The d present at that edge never appears at q; the next d
//     appears eff edges later.
//  6. Run-time delay change: delay 4 -> 2 mid-stream (d = 10, 11, 12, ...)
//     -> in the same cycle q jumps from the 4-edge-old sample to the 2-edge-old
//     sample (e.g. 13 to 15). Then change 2 -> 6 right after a clear ->
//     q_valid = 0 until 6 edges have elapsed.

Source files
------------

// File: rtl/var_delay_line_if.sv
// Stream interface for var_delay_line: control and sample inputs from the producer, delayed sample back out.
// The producer drives the master side; the delay line sits on the slave side.
interface var_delay_line_if #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 4
);
  logic               en;
  logic               clear;
  logic [DELAY_W-1:0] delay;
  logic [WIDTH-1:0]   d;
  logic               d_valid;
  logic [WIDTH-1:0]   q;
  logic               q_valid;

  modport master (
    output en, clear, delay, d, d_valid,
    input  q, q_valid
  );

  modport slave (
    input  en, clear, delay, d, d_valid,
    output q, q_valid
  );
endinterface

// File: rtl/var_delay_line.sv
// Run-time selectable delay line: MAX_DEPTH shift stages with per-sample valid, stall and flush.
// The output is a combinational tap select on the stage registers, so d never reaches q within a cycle.
module var_delay_line #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 8,
  parameter int DELAY_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  var_delay_line_if.slave   io
);

  if (WIDTH < 1) begin : g_bad_width
    $error("var_delay_line: WIDTH must be at least 1");
  end
  if (MAX_DEPTH < 1) begin : g_bad_depth
    $error("var_delay_line: MAX_DEPTH must be at least 1");
  end
  if ((2 ** DELAY_W) <= MAX_DEPTH) begin : g_bad_delay_w
    $error("var_delay_line: 2**DELAY_W must exceed MAX_DEPTH");
  end

  localparam logic [DELAY_W-1:0] MAX_DELAY = DELAY_W'(MAX_DEPTH);
  localparam logic [DELAY_W-1:0] MAX_SEL   = DELAY_W'(MAX_DEPTH - 1);

  // Element 0 is the newest stage; element k holds the sample from k+1 accepted edges ago.
  logic [MAX_DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [MAX_DEPTH-1:0]            stage_valid;

  logic [DELAY_W-1:0] tap_sel;
  logic [WIDTH-1:0]   tap_data;
  logic               tap_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data  <= '0;
      stage_valid <= '0;
    end else if (io.clear) begin
      stage_data  <= '0;
      stage_valid <= '0;
    end else if (io.en) begin
      stage_data[0]  <= io.d;
      stage_valid[0] <= io.d_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        stage_data[k]  <= stage_data[k-1];
        stage_valid[k] <= stage_valid[k-1];
      end
    end
  end

  // A zero delay still means one register of latency; anything past the last stage clamps to it.
  always_comb begin
    tap_sel = '0;
    if (io.delay == '0) begin
      tap_sel = '0;
    end else if (io.delay > MAX_DELAY) begin
      tap_sel = MAX_SEL;
    end else begin
      tap_sel = io.delay - DELAY_W'(1);
    end
  end

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (tap_sel == DELAY_W'(k)) begin
        tap_data  = stage_data[k];
        tap_valid = stage_valid[k];
      end
    end
  end

  assign io.q       = tap_data;
  assign io.q_valid = tap_valid;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: directed scenarios plus a randomized run against a history-queue model.
module tb_var_delay_line;
  localparam int WIDTH     = 8;
  localparam int MAX_DEPTH = 8;
  localparam int DELAY_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  var_delay_line_if #(.WIDTH(WIDTH), .DELAY_W(DELAY_W)) bus ();

  var_delay_line #(
    .WIDTH    (WIDTH),
    .MAX_DEPTH(MAX_DEPTH),
    .DELAY_W  (DELAY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  // History of accepted samples, newest first, each {data, valid}.
  logic [WIDTH:0] mq[$];

  function automatic int eff_of(input int dl);
    if (dl == 0) return 1;
    if (dl > MAX_DEPTH) return MAX_DEPTH;
    return dl;
  endfunction

  function automatic void model_flush();
    mq.delete();
    for (int i = 0; i < MAX_DEPTH; i++) mq.push_back('0);
  endfunction

  function automatic logic [WIDTH-1:0] exp_q();
    logic [WIDTH:0] e;
    e = mq[eff_of(int'(bus.delay)) - 1];
    return e[WIDTH:1];
  endfunction

  function automatic logic exp_v();
    logic [WIDTH:0] e;
    e = mq[eff_of(int'(bus.delay)) - 1];
    return e[0];
  endfunction

  task automatic step(input logic e, input logic c, input logic [WIDTH-1:0] dd, input logic dv);
    bus.en      = e;
    bus.clear   = c;
    bus.d       = dd;
    bus.d_valid = dv;
    @(posedge clk);
    if (c) begin
      model_flush();
    end else if (e) begin
      mq.push_front({dd, dv});
      void'(mq.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.clear = 1'b0; bus.delay = 4'd2; bus.d = '0; bus.d_valid = 1'b0;
    rst_n = 1'b0;
    model_flush();
    #12 rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h5A, 1'b1);
    step(1'b1, 1'b0, 8'h5B, 1'b1);
    step(1'b1, 1'b0, 8'h5C, 1'b1);
    checks++;
    if (bus.q !== 8'h5B || bus.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: q=%h v=%b expected q=5b v=1", bus.q, bus.q_valid);
    end
    #2 rst_n = 1'b0;
    model_flush();
    #1;
    checks++;
    if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: q=%h v=%b expected q=00 v=0", bus.q, bus.q_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: q=%h v=%b expected q=00 v=0", bus.q, bus.q_valid);
    end
    #3 rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h11, 1'b1);
    checks++;
    if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_edge1: q=%h v=%b expected q=00 v=0", bus.q, bus.q_valid);
    end
    step(1'b1, 1'b0, 8'h22, 1'b1);
    checks++;
    if (bus.q !== 8'h11 || bus.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_edge2: q=%h v=%b expected q=11 v=1", bus.q, bus.q_valid);
    end
  endtask

  task automatic test_lfsr();
    logic [15:0]      lfsr = 16'hACE1;
    logic [WIDTH-1:0] prev_d = '0;
    logic             fb;
    int               bad = 0;
    bus.delay = 4'd2;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, lfsr[7:0], 1'b1);
      if (i >= 1) begin
        checks++;
        if (bus.q !== prev_d || bus.q_valid !== 1'b1) begin
          errors++;
          bad++;
          if (bad <= 5)
            $display("FAIL lfsr_delay2[%0d]: q=%h v=%b expected q=%h v=1", i, bus.q, bus.q_valid, prev_d);
        end
      end
      prev_d = lfsr[7:0];
      fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
      lfsr = {fb, lfsr[15:1]};
    end
  endtask

  task automatic test_clamp();
    int dls[3] = '{8, 0, 15};
    int lat[3] = '{8, 1, 8};
    for (int t = 0; t < 3; t++) begin
      bus.delay = DELAY_W'(dls[t]);
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 1; i <= 12; i++) begin
        logic             ev;
        logic [WIDTH-1:0] eq;
        step(1'b1, 1'b0, WIDTH'(i), 1'b1);
        ev = (i >= lat[t]);
        eq = ev ? WIDTH'(i - lat[t] + 1) : '0;
        checks++;
        if (bus.q !== eq || bus.q_valid !== ev) begin
          errors++;
          $display("FAIL clamp_delay%0d[%0d]: q=%h v=%b expected q=%h v=%b", dls[t], i, bus.q, bus.q_valid, eq, ev);
        end
      end
    end
  endtask

  task automatic test_stall();
    int               n = 1;
    logic [WIDTH-1:0] hq;
    logic             hv;
    bus.delay = 4'd3;
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, WIDTH'(n), 1'b1);
      n++;
    end
    hq = bus.q;
    hv = bus.q_valid;
    checks++;
    if (hq !== WIDTH'(n - 3) || hv !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre: q=%h v=%b expected q=%h v=1", hq, hv, WIDTH'(n - 3));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, WIDTH'($urandom_range(100, 250)), 1'($urandom_range(0, 1)));
      checks++;
      if (bus.q !== hq || bus.q_valid !== hv) begin
        errors++;
        $display("FAIL stall_hold[%0d]: q=%h v=%b expected q=%h v=%b", i, bus.q, bus.q_valid, hq, hv);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, WIDTH'(n), 1'b1);
      checks++;
      if (bus.q !== WIDTH'(n - 2) || bus.q_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_resume[%0d]: q=%h v=%b expected q=%h v=1", i, bus.q, bus.q_valid, WIDTH'(n - 2));
      end
      n++;
    end
  endtask

  task automatic test_flush();
    bus.delay = 4'd3;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i), 1'b1);
    step(1'b1, 1'b1, 8'hAA, 1'b1);
    checks++;
    if (bus.q !== 8'h00 || bus.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_edge: q=%h v=%b expected q=00 v=0", bus.q, bus.q_valid);
    end
    for (int i = 1; i <= 5; i++) begin
      logic             ev;
      logic [WIDTH-1:0] eq;
      step(1'b1, 1'b0, WIDTH'(8'h60 + i), 1'b1);
      ev = (i >= 3);
      eq = ev ? WIDTH'(8'h60 + i - 2) : '0;
      checks++;
      if (bus.q !== eq || bus.q_valid !== ev) begin
        errors++;
        $display("FAIL flush_refill[%0d]: q=%h v=%b expected q=%h v=%b", i, bus.q, bus.q_valid, eq, ev);
      end
    end
  endtask

  task automatic test_delay_change();
    bus.delay = 4'd4;
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int v = 10; v <= 16; v++) step(1'b1, 1'b0, WIDTH'(v), 1'b1);
    checks++;
    if (bus.q !== 8'd13 || bus.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL change_before: q=%0d v=%b expected q=13 v=1", bus.q, bus.q_valid);
    end
    bus.delay = 4'd2;
    #1;
    checks++;
    if (bus.q !== 8'd15 || bus.q_valid !== 1'b1) begin
      errors++;
      $display("FAIL change_shorten: q=%0d v=%b expected q=15 v=1", bus.q, bus.q_valid);
    end
    step(1'b1, 1'b1, 8'h00, 1'b0);
    bus.delay = 4'd6;
    for (int i = 1; i <= 8; i++) begin
      logic             ev;
      logic [WIDTH-1:0] eq;
      step(1'b1, 1'b0, WIDTH'(100 + i), 1'b1);
      ev = (i >= 6);
      eq = ev ? WIDTH'(100 + i - 5) : '0;
      checks++;
      if (bus.q !== eq || bus.q_valid !== ev) begin
        errors++;
        $display("FAIL change_lengthen[%0d]: q=%0d v=%b expected q=%0d v=%b", i, bus.q, bus.q_valid, eq, ev);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] eq;
      logic             ev;
      bus.delay = DELAY_W'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
           WIDTH'($urandom), 1'($urandom_range(0, 1)));
      eq = exp_q();
      ev = exp_v();
      checks++;
      if (bus.q !== eq || bus.q_valid !== ev) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_edge[%0d]: q=%h v=%b expected q=%h v=%b", i, bus.q, bus.q_valid, eq, ev);
      end
      if (i % 8 == 0) begin
        bus.delay = DELAY_W'($urandom_range(0, 15));
        #1;
        eq = exp_q();
        ev = exp_v();
        checks++;
        if (bus.q !== eq || bus.q_valid !== ev) begin
          errors++;
          $display("FAIL random_tap[%0d]: q=%h v=%b expected q=%h v=%b", i, bus.q, bus.q_valid, eq, ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_clamp();
    test_stall();
    test_flush();
    test_delay_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
